// File: rtl/key_onehot_scan_pkg.sv
// -----------------------------------------------------------------------------
// key_onehot_scan_pkg
// Shared definitions for the key scanner and the downstream one-hot-to-code
// converter: default key count, scanner FSM state encoding and the code the
// converter displays for any word that is not exactly one-hot.
// -----------------------------------------------------------------------------
package key_onehot_scan_pkg;

    // Default number of key inputs (width of keyin / onehot).
    localparam int NKEYS_DEF = 10;

    // Code shown by the converter for a zero or multi-bit input word.
    localparam logic [3:0] CODE_INVALID = 4'hF;

    // Scanner FSM: wait for a press, then wait for every key to be released.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage : key_onehot_scan_pkg

// File: rtl/key_onehot_scan_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// One-bit synchronizer and debouncer. The raw input passes through a plain
// 2-FF synchronizer; on every sample tick the synchronized level is compared
// with the debounced level, and the debounced level only follows after
// DEBOUNCE_TICKS consecutive differing samples. A matching sample restarts
// the count.
// Ports:
//   clk   in  1  system clock
//   rst_n in  1  asynchronous active-low reset
//   tick  in  1  sample enable (one cycle per debounce period)
//   din   in  1  raw asynchronous input
//   db    out 1  debounced level (registered)
// -----------------------------------------------------------------------------
module key_debounce #(
    parameter int DEBOUNCE_TICKS = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic din,
    output logic db
);

    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync1_r;
    logic          sync2_r;
    logic [CW-1:0] cnt_r;
    logic          db_r;

    // Two-flop synchronizer, nothing between the flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
        end
    end

    // Debounce counter and debounced level; only advances on sample ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
            db_r  <= 1'b0;
        end else if (tick) begin
            if (sync2_r != db_r) begin
                // The Nth consecutive differing sample flips the level, so the
                // counter tops out at DEBOUNCE_TICKS-1 and never wraps.
                if (cnt_r == CNT_LAST) begin
                    db_r  <= sync2_r;
                    cnt_r <= CNT_ZERO;
                end else begin
                    cnt_r <= cnt_r + CNT_ONE;
                end
            end else begin
                cnt_r <= CNT_ZERO;
            end
        end else begin
            cnt_r <= cnt_r;
            db_r  <= db_r;
        end
    end

    assign db = db_r;

endmodule : key_debounce

// File: rtl/key_onehot_scan.sv
// -----------------------------------------------------------------------------
// key_onehot_scan
// Upstream stage of the one-hot-to-code converter. Synchronizes and debounces
// NKEYS raw key inputs, detects debounced rising edges and registers one
// accepted press as a one-hot word with a single-cycle strobe. Simultaneous
// new presses load an all-zero word (error, shown as the invalid code
// downstream). After an acceptance all further presses are ignored until
// every key has been released.
// Ports:
//   clk    in  1      system clock, rising edge
//   rst_n  in  1      asynchronous active-low reset
//   keyin  in  NKEYS  raw keys, active-high, asynchronous
//   clr    in  1      synchronous clear of onehot (an acceptance overrides)
//   onehot out NKEYS  last accepted key, 0 = none / multi-press error
//   strobe out 1      one-cycle pulse when onehot is loaded by an acceptance
//   busy   out 1      high while waiting for all keys to be released
// -----------------------------------------------------------------------------
module key_onehot_scan
    import key_onehot_scan_pkg::*;
#(
    parameter int NKEYS          = NKEYS_DEF,
    parameter int PRESCALE       = 50000,
    parameter int DEBOUNCE_TICKS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NKEYS-1:0] keyin,
    input  logic             clr,
    output logic [NKEYS-1:0] onehot,
    output logic             strobe,
    output logic             busy
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0]  PS_ZERO = PS_W'(0);
    localparam logic [PS_W-1:0]  PS_ONE  = PS_W'(1);
    localparam logic [NKEYS-1:0] K_ZERO  = {NKEYS{1'b0}};
    localparam logic [NKEYS-1:0] K_ONE   = {{(NKEYS-1){1'b0}}, 1'b1};

    logic [PS_W-1:0]  ps_cnt_r;
    logic             tick_s;
    logic [NKEYS-1:0] db_s;
    logic [NKEYS-1:0] db_prev_r;
    logic [NKEYS-1:0] rise_s;
    logic             single_s;
    state_t           state_r;
    state_t           state_n;
    logic [NKEYS-1:0] onehot_r;
    logic [NKEYS-1:0] onehot_n;
    logic             strobe_r;
    logic             strobe_n;

    // Free-running sample-tick prescaler (PRESCALE=1 ticks every cycle).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_cnt_r <= PS_ZERO;
        end else if (tick_s) begin
            ps_cnt_r <= PS_ZERO;
        end else begin
            ps_cnt_r <= ps_cnt_r + PS_ONE;
        end
    end

    assign tick_s = (ps_cnt_r == PS_LAST);

    // One synchronizer/debouncer per key.
    for (genvar g = 0; g < NKEYS; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
        ) u_debounce (
            .clk  (clk),
            .rst_n(rst_n),
            .tick (tick_s),
            .din  (keyin[g]),
            .db   (db_s[g])
        );
    end

    // Previous debounced levels for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_prev_r <= K_ZERO;
        end else begin
            db_prev_r <= db_s;
        end
    end

    assign rise_s = db_s & ~db_prev_r;
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign single_s = (rise_s != K_ZERO) && ((rise_s & (rise_s - K_ONE)) == K_ZERO);

    // FSM state, accepted word and strobe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            onehot_r <= K_ZERO;
            strobe_r <= 1'b0;
        end else begin
            state_r  <= state_n;
            onehot_r <= onehot_n;
            strobe_r <= strobe_n;
        end
    end

    // Next-state / next-output logic; an acceptance takes priority over clr.
    always_comb begin
        state_n  = state_r;
        onehot_n = clr ? K_ZERO : onehot_r;
        strobe_n = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rise_s != K_ZERO) begin
                    strobe_n = 1'b1;
                    onehot_n = single_s ? rise_s : K_ZERO;
                    state_n  = ST_HOLD;
                end else begin
                    state_n  = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (db_s == K_ZERO) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_HOLD;
                end
            end
            default: begin
                state_n  = ST_IDLE;
                onehot_n = K_ZERO;
                strobe_n = 1'b0;
            end
        endcase
    end

    assign onehot = onehot_r;
    assign strobe = strobe_r;
    assign busy   = (state_r == ST_HOLD);

endmodule : key_onehot_scan

// File: tb/tb_key_onehot_scan.sv
module tb_key_onehot_scan;

    logic       clk;
    logic       rst_n;
    logic [9:0] keyin;
    logic       clr;
    logic [9:0] onehot;
    logic       strobe;
    logic       busy;

    int checks;
    int errors;
    int strobe_cnt;
    int cyc;
    logic strobe_prev;
    logic dbl;

    key_onehot_scan #(
        .NKEYS(10),
        .PRESCALE(4),
        .DEBOUNCE_TICKS(3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .keyin (keyin),
        .clr   (clr),
        .onehot(onehot),
        .strobe(strobe),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedges since the last reset release (tracks the prescaler phase).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Strobe monitor: counts strobes and flags back-to-back pulses.
    initial begin
        strobe_cnt  = 0;
        strobe_prev = 1'b0;
        dbl         = 1'b0;
    end
    always @(negedge clk) begin
        if (strobe === 1'b1) begin
            strobe_cnt <= strobe_cnt + 1;
            if (strobe_prev === 1'b1) dbl <= 1'b1;
        end
        strobe_prev <= (strobe === 1'b1);
    end

    task automatic wait_strobe(input int maxc, output int n);
        int i;
        n = -1;
        i = 0;
        while (n < 0 && i < maxc) begin
            @(negedge clk);
            i++;
            if (strobe === 1'b1) n = i;
        end
    endtask

    task automatic wait_idle(input int maxc, output int n);
        int i;
        n = -1;
        i = 0;
        while (n < 0 && i < maxc) begin
            @(negedge clk);
            i++;
            if (busy === 1'b0) n = i;
        end
    endtask

    task automatic release_all(input string name);
        int n;
        keyin = 10'h000;
        wait_idle(60, n);
        checks++;
        if (n < 0) begin
            errors++;
            $display("FAIL %s_idle: busy=%b after 60 cycles, required 0", name, busy);
        end
    endtask

    task automatic test_reset;
        int n;
        rst_n = 1'b0;
        clr   = 1'b0;
        keyin = 10'h004;
        repeat (3) @(negedge clk);
        checks += 3;
        if (onehot !== 10'h000) begin errors++; $display("FAIL rst_onehot: got %h, required 000", onehot); end
        if (strobe !== 1'b0)    begin errors++; $display("FAIL rst_strobe: got %b, required 0", strobe); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
        rst_n = 1'b1;
        wait_strobe(40, n);
        checks++;
        if (n < 12 || n > 16) begin errors++; $display("FAIL held_latency: strobe after %0d cycles, required 12..16", n); end
        checks += 2;
        if (onehot !== 10'h004) begin errors++; $display("FAIL held_onehot: got %h, required 004", onehot); end
        if (busy !== 1'b1)      begin errors++; $display("FAIL held_busy: got %b, required 1", busy); end
        @(negedge clk);
        checks++;
        if (strobe !== 1'b0) begin errors++; $display("FAIL held_strobe_width: got %b, required 0", strobe); end
        release_all("held");
        checks++;
        if (onehot !== 10'h004) begin errors++; $display("FAIL held_keep: got %h, required 004", onehot); end
    endtask

    task automatic test_bounce;
        logic [19:0] pat;
        int snap;
        int n;
        // Ticks sample bounce positions 0,4,8,12,16 = 1,1,0,1,1: never three in a row.
        pat = 20'b0011_0011_0110_0011_0011;
        while (((cyc + 1) % 4) != 2) @(negedge clk);
        snap = strobe_cnt;
        for (int i = 0; i < 20; i++) begin
            keyin[3] = pat[i];
            @(negedge clk);
        end
        keyin[3] = 1'b1;
        checks++;
        if (strobe_cnt !== snap) begin errors++; $display("FAIL bounce_quiet: %0d strobes, required 0", strobe_cnt - snap); end
        wait_strobe(30, n);
        checks += 2;
        if (n < 0) begin errors++; $display("FAIL bounce_accept: no strobe, required one"); end
        if (onehot !== 10'h008) begin errors++; $display("FAIL bounce_onehot: got %h, required 008", onehot); end
        release_all("bounce");
    endtask

    task automatic test_multi;
        int n;
        keyin = 10'h201;
        wait_strobe(40, n);
        checks += 3;
        if (n < 0) begin errors++; $display("FAIL multi_strobe: no strobe, required one"); end
        if (onehot !== 10'h000) begin errors++; $display("FAIL multi_onehot: got %h, required 000", onehot); end
        if (busy !== 1'b1)      begin errors++; $display("FAIL multi_busy: got %b, required 1", busy); end
        @(negedge clk);
        checks++;
        if (strobe !== 1'b0) begin errors++; $display("FAIL multi_strobe_width: got %b, required 0", strobe); end
        release_all("multi");
    endtask

    task automatic test_hold;
        int n;
        int snap;
        keyin = 10'h001;
        wait_strobe(40, n);
        checks++;
        if (onehot !== 10'h001 || n < 0) begin errors++; $display("FAIL hold_first: got %h, required 001", onehot); end
        @(negedge clk);
        snap  = strobe_cnt;
        keyin = 10'h021;
        repeat (30) @(negedge clk);
        checks += 3;
        if (strobe_cnt !== snap) begin errors++; $display("FAIL hold_ignore: %0d strobes, required 0", strobe_cnt - snap); end
        if (onehot !== 10'h001)  begin errors++; $display("FAIL hold_onehot: got %h, required 001", onehot); end
        if (busy !== 1'b1)       begin errors++; $display("FAIL hold_busy: got %b, required 1", busy); end
        release_all("hold");
        keyin = 10'h020;
        wait_strobe(40, n);
        checks++;
        if (onehot !== 10'h020 || n < 0) begin errors++; $display("FAIL hold_second: got %h, required 020", onehot); end
        release_all("hold2");
    endtask

    task automatic test_clr;
        int n;
        keyin = 10'h004;
        wait_strobe(40, n);
        checks++;
        if (onehot !== 10'h004 || n < 0) begin errors++; $display("FAIL clr_pre: got %h, required 004", onehot); end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks += 2;
        if (onehot !== 10'h000) begin errors++; $display("FAIL clr_onehot: got %h, required 000", onehot); end
        if (busy !== 1'b1)      begin errors++; $display("FAIL clr_busy: got %b, required 1", busy); end
        release_all("clr");
        // clr held high across the acceptance of key9: the acceptance wins.
        clr   = 1'b1;
        keyin = 10'h200;
        wait_strobe(40, n);
        clr = 1'b0;
        checks += 2;
        if (n < 0) begin errors++; $display("FAIL clr_win_strobe: no strobe, required one"); end
        if (onehot !== 10'h200) begin errors++; $display("FAIL clr_win_onehot: got %h, required 200", onehot); end
        release_all("clr2");
    endtask

    task automatic test_reset_mid;
        int n;
        keyin = 10'h004;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (onehot !== 10'h000) begin errors++; $display("FAIL mid_rst_onehot: got %h, required 000", onehot); end
        if (strobe !== 1'b0)    begin errors++; $display("FAIL mid_rst_strobe: got %b, required 0", strobe); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL mid_rst_busy: got %b, required 0", busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_strobe(40, n);
        checks += 2;
        if (n < 12 || n > 16) begin errors++; $display("FAIL mid_latency: strobe after %0d cycles, required 12..16", n); end
        if (onehot !== 10'h004) begin errors++; $display("FAIL mid_onehot: got %h, required 004", onehot); end
        release_all("mid");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        clr    = 1'b0;
        keyin  = 10'h000;
        test_reset;
        test_bounce;
        test_multi;
        test_hold;
        test_clr;
        test_reset_mid;
        checks++;
        if (dbl !== 1'b0) begin errors++; $display("FAIL strobe_single: back-to-back strobe seen, required none"); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_key_onehot_scan
